// File: rtl/rr_arbiter8x3.sv
// rtl/rr_arbiter8x3.sv - eight-way round-robin arbiter with one-hot and binary grant
// Grants are held while the winner keeps requesting; an optional hold limit forces rotation.
module rr_arbiter8x3 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] code,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t            state_q;
  logic [2:0]        ptr_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [7:0]        grant_q;
  logic [2:0]        code_q;
  logic              valid_q;

  logic [2:0] start_d;
  logic [2:0] idx_d;
  logic [2:0] win_idx_d;
  logic       win_found_d;
  logic       timeout_d;

  // While granting, the search starts after the holder and skips it, covering both release and timeout.
  always_comb begin
    start_d     = (state_q == GRANT) ? code_q + 3'd1 : ptr_q;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    idx_d       = '0;
    for (int i = 7; i >= 0; i--) begin
      idx_d = start_d + 3'(i);
      if (req[idx_d] && !(state_q == GRANT && idx_d == code_q)) begin
        win_found_d = 1'b1;
        win_idx_d   = idx_d;
      end
    end
  end

  // A contender arriving after the limit already elapsed still gets rotated in at the next edge.
  assign timeout_d = (MAX_HOLD != 0) && (cnt_q >= HOLD_LAST) && req[code_q] && win_found_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            state_q <= GRANT;
            grant_q <= 8'(1) << win_idx_d;
            code_q  <= win_idx_d;
            valid_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (!req[code_q]) begin
            ptr_q <= code_q + 3'd1;
            cnt_q <= '0;
            if (win_found_d) begin
              grant_q <= 8'(1) << win_idx_d;
              code_q  <= win_idx_d;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              code_q  <= '0;
              valid_q <= 1'b0;
            end
          end else if (timeout_d) begin
            ptr_q   <= code_q + 3'd1;
            cnt_q   <= '0;
            grant_q <= 8'(1) << win_idx_d;
            code_q  <= win_idx_d;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + HOLD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign code  = code_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8x3.sv
// tb/tb_rr_arbiter8x3.sv - table-driven scoreboard bench for rr_arbiter8x3
// Two instances: hold limit disabled and hold limit of 4.
module tb_rr_arbiter8x3;

  typedef struct {
    logic       sel;
    logic [7:0] r;
    logic       v;
    logic [2:0] c;
  } vec_t;

  typedef struct {
    string      name;
    logic       sel;
    logic [7:0] grant;
    logic [2:0] code;
    logic       valid;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req0, req4;
  logic [7:0] grant0, grant4;
  logic [2:0] code0, code4;
  logic       valid0, valid4;

  int unsigned passed;
  int unsigned total;
  vec_t        vecs[$];
  exp_t        exp_q[$];

  rr_arbiter8x3 #(.MAX_HOLD(0), .HOLD_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0),
    .grant(grant0), .code(code0), .valid(valid0)
  );

  rr_arbiter8x3 #(.MAX_HOLD(4), .HOLD_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4),
    .grant(grant4), .code(code4), .valid(valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t make_exp(input string name, input logic sel, input logic v, input logic [2:0] c);
    exp_t e;
    logic [7:0] one;
    one     = 8'd1;
    e.name  = name;
    e.sel   = sel;
    e.valid = v;
    e.code  = v ? c : 3'd0;
    e.grant = v ? (one << c) : 8'd0;
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    logic [7:0] g;
    logic [2:0] c;
    logic       v;
    e = exp_q.pop_front();
    g = e.sel ? grant4 : grant0;
    c = e.sel ? code4  : code0;
    v = e.sel ? valid4 : valid0;
    total++;
    if (g === e.grant && c === e.code && v === e.valid) passed++;
    else $display("FAIL %s: got grant=%b code=%0d valid=%b, expected grant=%b code=%0d valid=%b",
                  e.name, g, c, v, e.grant, e.code, e.valid);
  endtask

  task automatic apply(input string name, input logic sel, input logic [7:0] r, input logic v, input logic [2:0] c);
    req0 = sel ? 8'd0 : r;
    req4 = sel ? r : 8'd0;
    exp_q.push_back(make_exp(name, sel, v, c));
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    rst_n = 1'b0;
    req0  = 8'd0;
    req4  = 8'd0;

    for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 8'h03, 1'b1, 3'((i / 4) % 2)});
    vecs.push_back('{1'b1, 8'h01, 1'b1, 3'd0});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 8'h01, 1'b1, 3'd0});
    vecs.push_back('{1'b1, 8'h00, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 3'd0});
    for (int h = 0; h < 8; h++) vecs.push_back('{1'b0, 8'hFF & ~(8'd1 << h), 1'b1, 3'((h + 1) % 8)});
    vecs.push_back('{1'b0, 8'h01, 1'b1, 3'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 8'h01, 1'b1, 3'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 8'h40, 1'b1, 3'd6});
    vecs.push_back('{1'b0, 8'h05, 1'b1, 3'd0});
    vecs.push_back('{1'b0, 8'h04, 1'b1, 3'd2});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 8'h91, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 8'h91, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 8'h81, 1'b1, 3'd7});
    vecs.push_back('{1'b0, 8'h01, 1'b1, 3'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 8'h20, 1'b1, 3'd5});

    #3;
    exp_q.push_back(make_exp("reset_dut0", 1'b0, 1'b0, 3'd0));
    check_pop();
    exp_q.push_back(make_exp("reset_dut4", 1'b1, 1'b0, 3'd0));
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d_req%02h", i, vecs[i].r);
      apply(nm, vecs[i].sel, vecs[i].r, vecs[i].v, vecs[i].c);
    end

    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(make_exp("async_reset_mid_grant", 1'b0, 1'b0, 3'd0));
    check_pop();
    req0 = 8'h21;
    @(negedge clk);
    rst_n = 1'b1;
    apply("ptr_cleared_after_reset", 1'b0, 8'h21, 1'b1, 3'd0);

    apply("hold4_sole_from_idle", 1'b1, 8'h01, 1'b1, 3'd0);
    apply("dut0_released", 1'b0, 8'h00, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
